seg_serial_driver: RTL and testbench
====================================

// Module: seg_serial_driver
// PURPOSE
//  Parametrised serial driver for the board's shift-register 7-segment display (SEGCLK/SEGCLR/SEGDT/SEGEN).
//  Accepts a display frame over a valid/ready handshake, in hex or raw-segment mode.
//  Serialises the frame to the display at a divided bit rate and manages clear/enable sequencing.
//  Instantiated in top; replaces ad-hoc per-board shifting logic.
// PARAMETERS
//  NUM_DIGITS      8  digits on the chain; frame = NUM_DIGITS*8 bits
//  CLK_DIV         2  clk cycles per SEGCLK half-period; must be >= 1
//  SEG_ACTIVE_LOW  1  1: segment/dp bits inverted before shifting (common-anode)
// PORTS
//  clk         in   1               system clock; all logic on posedge
//  rst         in   1               synchronous reset, active-low
//  in_valid    in   1               frame offered
//  in_ready    out  1               driver idle; accepts frame
//  in_mode     in   1               0: hex; 1: raw segments
//  in_data     in   NUM_DIGITS*8    hex: nibble i = in_data[4i+3:4i]; raw: byte i = {dp,g,f,e,d,c,b,a}
//  dp_mask     in   NUM_DIGITS      hex mode: decimal point per digit (1 = lit)
//  blank_mask  in   NUM_DIGITS      1 = digit fully off (both modes)
//  busy        out  1               high outside IDLE
//  SEGCLK      out  1               serial shift clock; display samples SEGDT on rising edge
//  SEGCLR      out  1               display clear, active-low
//  SEGDT       out  1               serial data
//  SEGEN       out  1               display output enable, active-high
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=CLEAR, SEGCLK=0, SEGCLR=0, SEGDT=0, SEGEN=0, in_ready=0, busy=1.
//    Applies in any state; a partial frame is abandoned and never resumed.
//  - FSM: CLEAR -> IDLE -> SHIFT -> DONE -> IDLE.
//  - CLEAR: SEGCLR=0 for 2*CLK_DIV cycles after rst releases, then SEGCLR=1 and go to IDLE.
//  - IDLE: in_ready=1, busy=0. When in_valid&&in_ready at a posedge, capture in_data/in_mode/dp_mask/blank_mask.
//    The captured frame is encoded into a NUM_DIGITS*8 shift register and the FSM enters SHIFT on the next cycle.
//  - Encoding: hex nibble -> 7-seg via decoder; dp bit = dp_mask[i]; raw mode uses the byte as-is.
//    Then blank_mask[i] forces the byte to 8'h00. Then the byte is inverted if SEG_ACTIVE_LOW.
//  - SHIFT: bit order is digit NUM_DIGITS-1 first, MSB (dp) first within each byte.
//    Each bit has two halves:
//      low half:  SEGCLK=0 for CLK_DIV cycles, SEGDT holds the bit;
//      high half: SEGCLK=1 for CLK_DIV cycles.
//    SEGDT changes only in the first cycle of a low half, so it is stable across every rising SEGCLK.
//    The SHIFT phase lasts NUM_DIGITS*16*CLK_DIV cycles.
//  - DONE: one cycle. SEGCLK=0; SEGEN goes 1 and stays 1 until the next reset. Then IDLE (in_ready=1 next cycle).
//  - in_valid during CLEAR/SHIFT/DONE: ignored, no capture; the source must hold it until in_ready.
//  - Counters:
//      divider: $clog2(CLK_DIV+1) bits;
//      bit counter: $clog2(NUM_DIGITS*8+1) bits;
//      both wrap only through FSM reload, never modulo.
//  - SEGCLR stays 1 outside CLEAR. SEGDT=0 in IDLE/DONE.
// STRUCTURE
//  - Package seg_pkg: state enum {CLEAR,IDLE,SHIFT,DONE}; segment constant table for 0-F ({g..a}, active-high).
//  - Sub-module seg_hex_decode: 4-bit in -> 7-bit segments (combinational, table from seg_pkg).
//    One instance per digit via generate.
//  - Top-level: FSM, divider counter, bit counter, shift register.
// TESTING (NUM_DIGITS=8, CLK_DIV=2, SEG_ACTIVE_LOW=1 unless noted; frame = 256 cycles)
//  1. rst=0 for 3 cycles, then 1
//     -> SEGCLR=0 for 4 further cycles, then 1; in_ready=1 on the 5th cycle; SEGEN=0.
//  2. hex in_data=32'h0123_4567, dp_mask=0, blank=0
//     -> 64 bits sampled on SEGCLK rises equal {C0,F9,A4,B0,99,92,82,F8}; 32 SEGCLK... 64 rising edges;
//        in_ready returns 257 cycles after accept; SEGEN=1.
//  3. raw in_data=64'hFF00_..., blank_mask=8'h80, mode=1
//     -> first byte shifted = 8'hFF (blanked: ~00); remaining bytes = ~raw.
//  4. in_valid held high through a frame with changing in_data
//     -> exactly one capture per IDLE cycle; second frame starts 1 cycle after in_ready rises;
//        mid-frame data changes do not appear.
//  5. rst=0 at the 20th SEGCLK rise
//     -> next cycle all outputs at reset values; after CLEAR, a new frame shifts all 64 bits correctly.
//  6. CLK_DIV=1, hex all 8'h88, dp_mask=8'hFF
//     -> SEGCLK toggles every cycle; every byte = 8'h00; frame = 128 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment serial driver: FSM encodings and the hex glyph table.
package seg_pkg;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [1:0] seg_state_t;

    // Glyphs for 0-F as {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// One digit of hex-to-segment decode, combinational.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_serial_driver.sv
// Serial driver for the shift-register 7-segment chain: frame capture, encoding,
// divided-rate shifting and clear/enable sequencing.
module seg_serial_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [NUM_DIGITS*8-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    busy,
    output logic                    SEGCLK,
    output logic                    SEGCLR,
    output logic                    SEGDT,
    output logic                    SEGEN
);

    localparam int NBITS = NUM_DIGITS * 8;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    seg_state_t                      state;
    logic [DIV_W-1:0]                div;
    logic                            half;
    logic [BIT_W-1:0]                bitcnt;
    logic [NBITS-1:0]                sreg;
    logic                            segen_q;
    logic [NUM_DIGITS-1:0][6:0]      hexseg;
    logic [NUM_DIGITS-1:0][7:0]      enc;

    // Per-digit encode: glyph or raw byte, then blanking, then polarity.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        logic [7:0] byte_sel;

        seg_hex_decode u_dec (
            .nib (in_data[4*g +: 4]),
            .seg (hexseg[g])
        );

        assign byte_sel = in_mode ? in_data[8*g +: 8] : {dp_mask[g], hexseg[g]};
        assign enc[g]   = (blank_mask[g] ? 8'h00 : byte_sel) ^ {8{SEG_ACTIVE_LOW != 0}};
    end

    wire div_end = (div == DIV_LAST);

    // CLEAR reuses the divider/half pair so its 2*CLK_DIV hold fits the divider width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            div     <= '0;
            half    <= 1'b0;
            bitcnt  <= '0;
            sreg    <= '0;
            segen_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (div_end) begin
                        div  <= '0;
                        half <= ~half;
                        if (half) state <= ST_IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (in_valid) begin
                        sreg   <= enc;
                        div    <= '0;
                        half   <= 1'b0;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!div_end) begin
                        div <= div + 1'b1;
                    end else begin
                        div  <= '0;
                        half <= ~half;
                        // Advance data only at the high->low boundary so SEGDT never moves under a rising edge.
                        if (half) begin
                            sreg   <= sreg << 1;
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BIT_LAST) begin
                                state   <= ST_DONE;
                                segen_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_CLEAR;
            endcase
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign SEGCLR   = (state != ST_CLEAR);
    assign SEGCLK   = (state == ST_SHIFT) & half;
    assign SEGDT    = (state == ST_SHIFT) & sreg[NBITS-1];
    assign SEGEN    = segen_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Randomized self-checking bench for seg_serial_driver (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_seg_serial_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  in_valid, in_mode;
    logic [63:0] in_data [2];
    logic [7:0]  dp_mask [2];
    logic [7:0]  blank_mask [2];
    logic [1:0]  in_ready, busy, segclk, segclr, segdt, segen;

    int total  = 0;
    int passed = 0;
    int acc0   = 0;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_serial_driver #(.NUM_DIGITS(8), .CLK_DIV(2), .SEG_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mode(in_mode[0]), .in_data(in_data[0]), .dp_mask(dp_mask[0]),
        .blank_mask(blank_mask[0]), .busy(busy[0]), .SEGCLK(segclk[0]),
        .SEGCLR(segclr[0]), .SEGDT(segdt[0]), .SEGEN(segen[0])
    );

    seg_serial_driver #(.NUM_DIGITS(8), .CLK_DIV(1), .SEG_ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mode(in_mode[1]), .in_data(in_data[1]), .dp_mask(dp_mask[1]),
        .blank_mask(blank_mask[1]), .busy(busy[1]), .SEGCLK(segclk[1]),
        .SEGCLR(segclr[1]), .SEGDT(segdt[1]), .SEGEN(segen[1])
    );

    // Display-side view: SEGDT as seen at each SEGCLK rise.
    logic rx0 [$];
    logic rx1 [$];
    logic [1:0] pclk = 2'b00;
    always @(negedge clk) begin
        if (segclk[0] && !pclk[0]) rx0.push_back(segdt[0]);
        if (segclk[1] && !pclk[1]) rx1.push_back(segdt[1]);
        pclk <= segclk;
    end

    always @(posedge clk) if (rst && in_valid[0] && in_ready[0]) acc0 <= acc0 + 1;

    // Expected stream: digit 7 first, MSB first; bit 63 is the first bit out.
    function automatic logic [63:0] model(input logic mode, input logic [63:0] d,
                                          input logic [7:0] dp, input logic [7:0] bl);
        logic [63:0] r;
        logic [7:0]  b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (bl[i])     b = 8'h00;
            else if (mode) b = d[8*i +: 8];
            else           b = {dp[i], GLYPH[d[4*i +: 4]]};
            r[8*i +: 8] = ~b;
        end
        return r;
    endfunction

    function automatic logic [63:0] pack_rx(input int sel);
        logic [63:0] g;
        g = '0;
        if (sel == 0) for (int j = 0; j < rx0.size(); j++) g = {g[62:0], rx0[j]};
        else          for (int j = 0; j < rx1.size(); j++) g = {g[62:0], rx1[j]};
        return g;
    endfunction

    function automatic int rx_size(input int sel);
        return (sel == 0) ? rx0.size() : rx1.size();
    endfunction

    task automatic wait_ready(input int sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready[sel]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input int sel, input string name, input logic mode,
                             input logic [63:0] d, input logic [7:0] dp, input logic [7:0] bl);
        bit ok;
        int n, lat;
        logic [63:0] exp_s, got;
        lat = (sel == 0) ? 257 : 129;
        exp_s = model(mode, d, dp, bl);
        wait_ready(sel, 2000, ok);
        total++;
        if (ok !== 1'b1) $display("FAIL %s ready_timeout got=%0b want=1", name, ok);
        else passed++;
        in_mode[sel] = mode; in_data[sel] = d; dp_mask[sel] = dp; blank_mask[sel] = bl;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        if (sel == 0) rx0.delete(); else rx1.delete();
        #1 in_valid[sel] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready[sel] && n < 2000);
        total++;
        if (n - 1 !== lat) $display("FAIL %s latency got=%0d want=%0d", name, n - 1, lat);
        else passed++;
        total++;
        if (rx_size(sel) !== 64) $display("FAIL %s rises got=%0d want=64", name, rx_size(sel));
        else passed++;
        got = pack_rx(sel);
        total++;
        if (got !== exp_s) $display("FAIL %s stream got=%h want=%h", name, got, exp_s);
        else passed++;
        total++;
        if (segen[sel] !== 1'b1) $display("FAIL %s segen got=%b want=1", name, segen[sel]);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({segclk[0], segclr[0], segdt[0], segen[0], in_ready[0], busy[0]} !== 6'b000001)
            $display("FAIL reset_outputs got=%b want=000001",
                     {segclk[0], segclr[0], segdt[0], segen[0], in_ready[0], busy[0]});
        else passed++;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if ({segclr[0], in_ready[0], segen[0]} !== {(k >= 5), (k == 5), 1'b0})
                $display("FAIL clear_seq cycle=%0d got=%b want=%b", k,
                         {segclr[0], in_ready[0], segen[0]}, {(k >= 5), (k == 5), 1'b0});
            else passed++;
        end
    endtask

    task automatic test_hex();
        run_frame(0, "hex_fixed", 1'b0, 64'h0000_0000_0123_4567, 8'h00, 8'h00);
    endtask

    task automatic test_raw_blank();
        run_frame(0, "raw_blank", 1'b1, 64'hFF00_A5C3_0F81_7E24, 8'h00, 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_frame(0, "random", 1'($urandom), {$urandom(), $urandom()},
                      8'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n, a0;
        logic [63:0] da, db, got;
        logic [7:0] dpa;
        da = {$urandom(), $urandom()};
        db = {$urandom(), $urandom()};
        dpa = 8'($urandom);
        wait_ready(0, 2000, ok);
        total++;
        if (ok !== 1'b1) $display("FAIL b2b_ready got=%0b want=1", ok); else passed++;
        in_mode[0] = 1'b0; in_data[0] = da; dp_mask[0] = dpa; blank_mask[0] = 8'h00;
        a0 = acc0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        rx0.delete();
        @(negedge clk);
        n = 1;
        in_data[0] = {$urandom(), $urandom()};
        repeat (100) begin @(negedge clk); n++; end
        in_data[0] = db;
        while (!in_ready[0] && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (n - 1 !== 257) $display("FAIL b2b_latency got=%0d want=257", n - 1); else passed++;
        got = pack_rx(0);
        total++;
        if (got !== model(1'b0, da, dpa, 8'h00))
            $display("FAIL b2b_first got=%h want=%h", got, model(1'b0, da, dpa, 8'h00));
        else passed++;
        rx0.delete();
        @(negedge clk);
        total++;
        if ({in_ready[0], busy[0]} !== 2'b01)
            $display("FAIL b2b_restart got=%b want=01", {in_ready[0], busy[0]});
        else passed++;
        in_valid[0] = 1'b0;
        wait_ready(0, 2000, ok);
        got = pack_rx(0);
        total++;
        if (got !== model(1'b0, db, dpa, 8'h00))
            $display("FAIL b2b_second got=%h want=%h", got, model(1'b0, db, dpa, 8'h00));
        else passed++;
        total++;
        if (acc0 - a0 !== 2) $display("FAIL b2b_captures got=%0d want=2", acc0 - a0);
        else passed++;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n;
        wait_ready(0, 2000, ok);
        in_mode[0] = 1'b0; in_data[0] = {$urandom(), $urandom()};
        dp_mask[0] = 8'h5A; blank_mask[0] = 8'h00;
        in_valid[0] = 1'b1;
        @(posedge clk);
        rx0.delete();
        #1 in_valid[0] = 1'b0;
        n = 0;
        while (rx0.size() < 20 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (rx0.size() !== 20) $display("FAIL midrst_rises got=%0d want=20", rx0.size());
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({segclk[0], segclr[0], segdt[0], segen[0], in_ready[0], busy[0]} !== 6'b000001)
            $display("FAIL midrst_outputs got=%b want=000001",
                     {segclk[0], segclr[0], segdt[0], segen[0], in_ready[0], busy[0]});
        else passed++;
        rst = 1'b1;
        run_frame(0, "after_reset", 1'b1, {$urandom(), $urandom()}, 8'h00, 8'($urandom));
    endtask

    task automatic test_div1();
        bit ok;
        int bad;
        logic [63:0] got;
        wait_ready(1, 2000, ok);
        in_mode[1] = 1'b0; in_data[1] = {$urandom(), 32'h8888_8888};
        dp_mask[1] = 8'hFF; blank_mask[1] = 8'h00;
        in_valid[1] = 1'b1;
        @(posedge clk);
        rx1.delete();
        #1 in_valid[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (segclk[1] !== 1'(k % 2) || in_ready[1] !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL div1_toggle got=%0d bad_cycles want=0", bad); else passed++;
        @(negedge clk);
        total++;
        if ({segclk[1], in_ready[1]} !== 2'b00)
            $display("FAIL div1_done got=%b want=00", {segclk[1], in_ready[1]});
        else passed++;
        @(negedge clk);
        total++;
        if (in_ready[1] !== 1'b1) $display("FAIL div1_ready got=%b want=1", in_ready[1]);
        else passed++;
        got = pack_rx(1);
        total++;
        if (got !== 64'h0 || rx1.size() !== 64)
            $display("FAIL div1_stream got=%h n=%0d want=0 n=64", got, rx1.size());
        else passed++;
        run_frame(1, "div1_random", 1'($urandom), {$urandom(), $urandom()},
                  8'($urandom), 8'($urandom));
    endtask

    initial begin
        in_valid = '0; in_mode = '0;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0; dp_mask[i] = '0; blank_mask[i] = '0;
        end
        test_reset();
        test_hex();
        test_raw_blank();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_div1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
